// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: a read-only fetch port and a load/store data port share one memory bus.
// Define FFR_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data has fixed priority over fetch.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic [DATA_WIDTH-1:0] fetchRdata,
    output logic                  fetchAck,

    input  logic                  dataReq,
    input  logic                  dataWe,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] dataWdata,
    output logic [DATA_WIDTH-1:0] dataRdata,
    output logic                  dataAck,

    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memReady,

    output logic                  timeoutErr,
    output logic [1:0]            arbState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DATA   = 2'd2,
        UNUSED = 2'd3
    } state_e;

    localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_LIMIT[WAIT_W-1:0];

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    fetch_ack_q, fetch_ack_d;
    logic                    data_ack_q, data_ack_d;
    logic                    timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

    logic fetch_ok;
    logic data_ok;
    logic grant_fetch;
    logic grant_data;
    logic busy;
    logic done;
    logic abort;

    // A requester is still holding req during its own ack cycle; masking it
    // there prevents the same access from being replayed.
    assign fetch_ok = fetchReq & ~fetch_ack_q;
    assign data_ok  = dataReq  & ~data_ack_q;

`ifdef FFR_ARB_ROUND_ROBIN_EN
    logic last_fetch_q, last_fetch_d;

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE) begin
            if (fetch_ok && data_ok) begin
                grant_fetch = ~last_fetch_q;
                grant_data  = last_fetch_q;
            end else begin
                grant_fetch = fetch_ok;
                grant_data  = data_ok;
            end
        end
    end

    always_comb begin
        last_fetch_d = last_fetch_q;
        if (grant_fetch) begin
            last_fetch_d = 1'b1;
        end else if (grant_data) begin
            last_fetch_d = 1'b0;
        end
    end

    // Reset value 0 means "data granted last", so the first tie goes to fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_fetch_q <= 1'b0;
        end else begin
            last_fetch_q <= last_fetch_d;
        end
    end
`else
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE) begin
            grant_data  = data_ok;
            grant_fetch = fetch_ok & ~data_ok;
        end
    end
`endif

    assign busy = (state_q == FETCH) || (state_q == DATA);
    assign done = busy && memReady;
    // The counter holds the number of ready-low cycles seen so far; the cycle in
    // which it equals the limit is the last chance for memReady to complete.
    assign abort = busy && !memReady && (WAIT_LIMIT != 0) && (wait_q == WAIT_MAX);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wait_d        = wait_q;
        fetch_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        timeout_d     = 1'b0;
        fetch_rdata_d = fetch_rdata_q;
        data_rdata_d  = data_rdata_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (grant_data) begin
                    state_d = DATA;
                    addr_d  = dataAddr;
                    we_d    = dataWe;
                    wdata_d = dataWdata;
                end else if (grant_fetch) begin
                    state_d = FETCH;
                    addr_d  = fetchAddr;
                    we_d    = 1'b0;
                end
            end
            FETCH, DATA: begin
                if (done || abort) begin
                    state_d     = IDLE;
                    wait_d      = '0;
                    fetch_ack_d = (state_q == FETCH);
                    data_ack_d  = (state_q == DATA);
                    timeout_d   = abort;
                    if (done && state_q == FETCH) begin
                        fetch_rdata_d = memRdata;
                    end
                    if (done && state_q == DATA) begin
                        data_rdata_d = memRdata;
                    end
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wait_q        <= '0;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            timeout_q     <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            wait_q        <= wait_d;
            fetch_ack_q   <= fetch_ack_d;
            data_ack_q    <= data_ack_d;
            timeout_q     <= timeout_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    // memReq decodes the state register directly, so reset drops it at once.
    assign memReq     = busy;
    assign memWe      = busy && we_q;
    assign memAddr    = busy ? addr_q : '0;
    assign memWdata   = busy ? wdata_q : '0;
    assign fetchAck   = fetch_ack_q;
    assign dataAck    = data_ack_q;
    assign fetchRdata = fetch_rdata_q;
    assign dataRdata  = data_rdata_q;
    assign timeoutErr = timeout_q;
    assign arbState   = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, wait limit and rdata.
module tb_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetchReq;
    logic [AW-1:0] fetchAddr;
    logic [DW-1:0] fetchRdata;
    logic          fetchAck;
    logic          dataReq;
    logic          dataWe;
    logic [AW-1:0] dataAddr;
    logic [DW-1:0] dataWdata;
    logic [DW-1:0] dataRdata;
    logic          dataAck;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic          memReady;
    logic          timeoutErr;
    logic [1:0]    arbState;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] exp_frd;
    logic [DW-1:0] exp_drd;
    bit            last_fetch;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchRdata(fetchRdata), .fetchAck(fetchAck),
        .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWdata(dataWdata),
        .dataRdata(dataRdata), .dataAck(dataAck),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady),
        .timeoutErr(timeoutErr), .arbState(arbState)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_timeout(input int waits);
        return (WL > 0) && (waits > WL);
    endfunction

    function automatic int exp_cycles(input int waits);
        return exp_timeout(waits) ? WL + 1 : waits + 1;
    endfunction

    function automatic bit pick_fetch(input bit f, input bit d);
`ifdef FFR_ARB_ROUND_ROBIN_EN
        if (f && d) return !last_fetch;
`endif
        return f && !d;
    endfunction

    function automatic int rand_waits();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return WL + 1 + int'($urandom_range(0, 3));
        if (r == 1) return WL;
        return int'($urandom_range(0, 4));
    endfunction

    // Memory responder: memReady stays low for 'waits' memReq cycles, then high.
    // Returns at the negedge of the first cycle after memReq drops.
    task automatic serve(input int waits, input logic [DW-1:0] rd, input bit scramble,
                         output int lat, output int ncyc, output logic [AW-1:0] a,
                         output logic we, output logic [DW-1:0] wd, output bit stable);
        lat = 0; ncyc = 0; stable = 1'b1; a = '0; we = 1'b0; wd = '0;
        while (memReq !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (memReq !== 1'b1) begin
            ncyc = -1;
            return;
        end
        a = memAddr; we = memWe; wd = memWdata;
        while (memReq === 1'b1 && ncyc < 4 * WL + 8) begin
            if (memAddr !== a || memWe !== we || memWdata !== wd ||
                timeoutErr !== 1'b0 || fetchAck !== 1'b0 || dataAck !== 1'b0)
                stable = 1'b0;
            memReady = (ncyc >= waits);
            memRdata = memReady ? rd : $urandom;
            if (scramble) begin
                dataAddr = $urandom; dataWdata = $urandom;
                dataWe = 1'($urandom_range(0, 1)); fetchAddr = $urandom;
            end
            ncyc++;
            @(negedge clk);
        end
        memReady = 1'b0;
        memRdata = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; fetchReq = 1'b0; dataReq = 1'b0; memReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_frd = '0; exp_drd = '0; last_fetch = 1'b0;
    endtask

    task automatic test_reset();
        int lat, ncyc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st;
        reset = 1'b1; fetchReq = 1'b1; dataReq = 1'b0; dataWe = 1'b1;
        fetchAddr = 32'h0000_0040; dataAddr = $urandom; dataWdata = $urandom;
        memReady = 1'b1; memRdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL rst_memReq got=%b exp=0", memReq); end
        n_checks++; if (memWe !== 1'b0) begin n_fail++; $display("FAIL rst_memWe got=%b exp=0", memWe); end
        n_checks++; if (memAddr !== '0) begin n_fail++; $display("FAIL rst_memAddr got=%h exp=0", memAddr); end
        n_checks++; if (fetchAck !== 1'b0 || dataAck !== 1'b0) begin n_fail++; $display("FAIL rst_acks got=%b%b exp=00", fetchAck, dataAck); end
        n_checks++; if (fetchRdata !== '0 || dataRdata !== '0) begin n_fail++; $display("FAIL rst_rdata got=%h/%h exp=0/0", fetchRdata, dataRdata); end
        n_checks++; if (timeoutErr !== 1'b0) begin n_fail++; $display("FAIL rst_timeoutErr got=%b exp=0", timeoutErr); end
        n_checks++; if (arbState !== 2'd0) begin n_fail++; $display("FAIL rst_arbState got=%0d exp=0", arbState); end
        reset = 1'b0;
        exp_frd = '0; exp_drd = '0; last_fetch = 1'b0;
        #1;
        n_checks++; if (arbState !== 2'd0) begin n_fail++; $display("FAIL rst_release_nogrant got=%0d exp=0", arbState); end
        @(negedge clk);
        n_checks++; if (arbState !== 2'd1) begin n_fail++; $display("FAIL rst_first_grant got=%0d exp=1", arbState); end
        rd = $urandom;
        serve(0, rd, 1'b0, lat, ncyc, a, we, wd, st);
        last_fetch = 1'b1; exp_frd = rd;
        n_checks++; if (fetchAck !== 1'b1 || fetchRdata !== exp_frd) begin n_fail++; $display("FAIL rst_first_fetch ack=%b rdata=%h exp ack=1 rdata=%h", fetchAck, fetchRdata, exp_frd); end
        fetchReq = 1'b0;
        $display("txn reset_fetch: F addr=%h cycles=%0d", a, ncyc);
    endtask

    task automatic test_single_fetch();
        int lat, ncyc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic we;
        bit st;
        @(negedge clk);
        fetchReq = 1'b1; fetchAddr = 32'h100;
        serve(1, 32'hDEADBEEF, 1'b0, lat, ncyc, a, we, wd, st);
        last_fetch = 1'b1; exp_frd = 32'hDEADBEEF;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=1", lat); end
        n_checks++; if (ncyc !== 2) begin n_fail++; $display("FAIL fetch_cycles got=%0d exp=2", ncyc); end
        n_checks++; if (a !== 32'h100 || we !== 1'b0) begin n_fail++; $display("FAIL fetch_bus addr=%h we=%b exp addr=100 we=0", a, we); end
        n_checks++; if (fetchAck !== 1'b1 || dataAck !== 1'b0) begin n_fail++; $display("FAIL fetch_ack got=%b%b exp=10", fetchAck, dataAck); end
        n_checks++; if (fetchRdata !== exp_frd) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=%h", fetchRdata, exp_frd); end
        n_checks++; if (timeoutErr !== 1'b0) begin n_fail++; $display("FAIL fetch_terr got=%b exp=0", timeoutErr); end
        fetchReq = 1'b0;
        $display("txn single_fetch: F addr=%h cycles=%0d rdata=%h", a, ncyc, fetchRdata);
        @(negedge clk);
        n_checks++; if (fetchAck !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse got=%b exp=0", fetchAck); end
    endtask

    task automatic test_store();
        int lat, ncyc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st;
        rd = $urandom;
        @(negedge clk);
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = 32'h200; dataWdata = 32'h12345678;
        serve(3, rd, 1'b1, lat, ncyc, a, we, wd, st);
        last_fetch = 1'b0; exp_drd = rd;
        n_checks++; if (ncyc !== 4) begin n_fail++; $display("FAIL store_cycles got=%0d exp=4", ncyc); end
        n_checks++; if (a !== 32'h200 || we !== 1'b1 || wd !== 32'h12345678) begin n_fail++; $display("FAIL store_bus addr=%h we=%b wdata=%h exp 200/1/12345678", a, we, wd); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL store_stable got=%b exp=1", st); end
        n_checks++; if (dataAck !== 1'b1 || fetchAck !== 1'b0) begin n_fail++; $display("FAIL store_ack got=%b%b exp=01", fetchAck, dataAck); end
        n_checks++; if (dataRdata !== exp_drd) begin n_fail++; $display("FAIL store_rdata got=%h exp=%h", dataRdata, exp_drd); end
        dataReq = 1'b0; dataWe = 1'b0;
        $display("txn store: D addr=%h wdata=%h cycles=%0d", a, wd, ncyc);
        @(negedge clk);
        n_checks++; if (dataAck !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse got=%b exp=0", dataAck); end
    endtask

    task automatic test_timeout();
        int lat, ncyc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st;
        @(negedge clk);
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = $urandom;
        serve(1000, 32'hBAD0BAD0, 1'b0, lat, ncyc, a, we, wd, st);
        last_fetch = 1'b0;
        n_checks++; if (ncyc !== WL + 1) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", ncyc, WL + 1); end
        n_checks++; if (dataAck !== 1'b1 || timeoutErr !== 1'b1) begin n_fail++; $display("FAIL timeout_ack ack=%b terr=%b exp 1/1", dataAck, timeoutErr); end
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL timeout_memReq got=%b exp=0", memReq); end
        n_checks++; if (dataRdata !== exp_drd) begin n_fail++; $display("FAIL timeout_rdata got=%h exp=%h", dataRdata, exp_drd); end
        dataReq = 1'b0;
        $display("txn timeout: D addr=%h cycles=%0d", a, ncyc);
        @(negedge clk);
        n_checks++; if (timeoutErr !== 1'b0 || dataAck !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse terr=%b ack=%b exp 0/0", timeoutErr, dataAck); end
        // memReady arriving in the cycle the count equals the limit must win
        rd = $urandom;
        @(negedge clk);
        dataReq = 1'b1; dataAddr = $urandom;
        serve(WL, rd, 1'b0, lat, ncyc, a, we, wd, st);
        exp_drd = rd;
        n_checks++; if (ncyc !== WL + 1) begin n_fail++; $display("FAIL limit_cycles got=%0d exp=%0d", ncyc, WL + 1); end
        n_checks++; if (dataAck !== 1'b1 || timeoutErr !== 1'b0) begin n_fail++; $display("FAIL limit_ack ack=%b terr=%b exp 1/0", dataAck, timeoutErr); end
        n_checks++; if (dataRdata !== exp_drd) begin n_fail++; $display("FAIL limit_rdata got=%h exp=%h", dataRdata, exp_drd); end
        dataReq = 1'b0;
        $display("txn ready_at_limit: D addr=%h cycles=%0d", a, ncyc);
    endtask

    task automatic test_idle_ready();
        @(negedge clk);
        memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memRdata = $urandom;
            @(negedge clk);
        end
        n_checks++; if (arbState !== 2'd0 || fetchAck !== 1'b0 || dataAck !== 1'b0) begin n_fail++; $display("FAIL idle_ready state=%0d acks=%b%b exp 0/00", arbState, fetchAck, dataAck); end
        n_checks++; if (fetchRdata !== exp_frd || dataRdata !== exp_drd) begin n_fail++; $display("FAIL idle_rdata got=%h/%h exp=%h/%h", fetchRdata, dataRdata, exp_frd, exp_drd); end
        memReady = 1'b0;
    endtask

    task automatic test_ack_mask();
        int lat, ncyc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st;
        rd = $urandom;
        @(negedge clk);
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = $urandom;
        serve(0, rd, 1'b0, lat, ncyc, a, we, wd, st);
        last_fetch = 1'b0; exp_drd = rd;
        n_checks++; if (dataAck !== 1'b1) begin n_fail++; $display("FAIL mask_ack got=%b exp=1", dataAck); end
        $display("txn ack_mask: D addr=%h cycles=%0d", a, ncyc);
        @(negedge clk);
        n_checks++; if (arbState !== 2'd0) begin n_fail++; $display("FAIL mask_no_regrant got=%0d exp=0", arbState); end
        dataReq = 1'b0;
    endtask

    task automatic test_contention();
        int lat, ncyc;
        logic [AW-1:0] a, fa, da;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st, own_fetch;
        logic [3:0] got_seq, want_seq;
        do_reset();
        got_seq = '0;
`ifdef FFR_ARB_ROUND_ROBIN_EN
        want_seq = 4'b0101;
`else
        want_seq = 4'b0000;
`endif
        for (int r = 0; r < 4; r++) begin
            fa = 32'hF000 + r; da = 32'hD000 + r; rd = $urandom;
            @(negedge clk);
            fetchReq = 1'b1; dataReq = 1'b1; dataWe = 1'b0;
            fetchAddr = fa; dataAddr = da;
            own_fetch = pick_fetch(1'b1, 1'b1);
            last_fetch = own_fetch;
            if (own_fetch) exp_frd = rd; else exp_drd = rd;
            serve(r % 3, rd, 1'b0, lat, ncyc, a, we, wd, st);
            got_seq[r] = (a == fa);
            n_checks++; if (a !== (own_fetch ? fa : da)) begin n_fail++; $display("FAIL contend_owner r=%0d addr=%h exp=%h", r, a, own_fetch ? fa : da); end
            n_checks++; if (fetchAck !== own_fetch || dataAck !== !own_fetch) begin n_fail++; $display("FAIL contend_ack r=%0d got=%b%b exp=%b%b", r, fetchAck, dataAck, own_fetch, !own_fetch); end
            $display("txn contend %0d: %s addr=%h", r, own_fetch ? "F" : "D", a);
            fetchReq = 1'b0; dataReq = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (got_seq !== want_seq) begin n_fail++; $display("FAIL contend_sequence got=%b exp=%b", got_seq, want_seq); end
    endtask

    task automatic test_mid_reset();
        int lat, ncyc;
        logic [AW-1:0] a, addr;
        logic [DW-1:0] wd, rd;
        logic we;
        bit st;
        @(negedge clk);
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = $urandom; dataWdata = $urandom;
        @(negedge clk);
        n_checks++; if (arbState !== 2'd2 || memReq !== 1'b1) begin n_fail++; $display("FAIL midrst_busy state=%0d memReq=%b exp 2/1", arbState, memReq); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (memReq !== 1'b0 || arbState !== 2'd0) begin n_fail++; $display("FAIL midrst_async memReq=%b state=%0d exp 0/0", memReq, arbState); end
        n_checks++; if (dataAck !== 1'b0 || dataRdata !== '0) begin n_fail++; $display("FAIL midrst_clear ack=%b rdata=%h exp 0/0", dataAck, dataRdata); end
        @(negedge clk);
        dataReq = 1'b0; reset = 1'b0;
        exp_frd = '0; exp_drd = '0; last_fetch = 1'b0;
        @(negedge clk);
        n_checks++; if (dataAck !== 1'b0 || arbState !== 2'd0) begin n_fail++; $display("FAIL midrst_noack ack=%b state=%0d exp 0/0", dataAck, arbState); end
        rd = $urandom; addr = $urandom;
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = addr;
        serve(2, rd, 1'b0, lat, ncyc, a, we, wd, st);
        exp_drd = rd;
        n_checks++; if (ncyc !== 3 || a !== addr || dataAck !== 1'b1 || dataRdata !== exp_drd) begin n_fail++; $display("FAIL midrst_fresh cycles=%0d addr=%h ack=%b rdata=%h exp 3/%h/1/%h", ncyc, a, dataAck, dataRdata, addr, exp_drd); end
        dataReq = 1'b0;
        $display("txn after_reset: D addr=%h cycles=%0d", a, ncyc);
    endtask

    task automatic test_random(input int iters);
        int lat, ncyc, waits, wf, wdw, kind, nacc;
        logic [AW-1:0] a, fa, da;
        logic [DW-1:0] wd, dwd, rf, rdd, rdv;
        logic we, dwe;
        bit st, hf, hd, first_fetch, own_fetch, to;
        for (int it = 0; it < iters; it++) begin
            kind = int'($urandom_range(1, 3));
            hf = kind[0]; hd = kind[1];
            fa = $urandom; da = $urandom; dwd = $urandom; dwe = 1'($urandom_range(0, 1));
            rf = $urandom; rdd = $urandom;
            wf = rand_waits(); wdw = rand_waits();
            @(negedge clk);
            fetchReq = hf; dataReq = hd; fetchAddr = fa; dataAddr = da;
            dataWdata = dwd; dataWe = dwe;
            first_fetch = pick_fetch(hf, hd);
            nacc = (hf && hd) ? 2 : 1;
            for (int k = 0; k < nacc; k++) begin
                own_fetch = (k == 0) ? first_fetch : !first_fetch;
                waits = own_fetch ? wf : wdw;
                rdv = own_fetch ? rf : rdd;
                to = exp_timeout(waits);
                last_fetch = own_fetch;
                if (!to) begin
                    if (own_fetch) exp_frd = rdv; else exp_drd = rdv;
                end
                serve(waits, rdv, 1'b0, lat, ncyc, a, we, wd, st);
                n_checks++; if (lat !== 1 || ncyc !== exp_cycles(waits)) begin n_fail++; $display("FAIL rnd_timing it=%0d lat=%0d cycles=%0d exp 1/%0d", it, lat, ncyc, exp_cycles(waits)); end
                n_checks++; if (a !== (own_fetch ? fa : da)) begin n_fail++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, a, own_fetch ? fa : da); end
                n_checks++; if (we !== (own_fetch ? 1'b0 : dwe)) begin n_fail++; $display("FAIL rnd_we it=%0d got=%b exp=%b", it, we, own_fetch ? 1'b0 : dwe); end
                if (!own_fetch) begin
                    n_checks++; if (wd !== dwd) begin n_fail++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, wd, dwd); end
                end
                n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd_stable it=%0d got=%b exp=1", it, st); end
                n_checks++; if (fetchAck !== own_fetch || dataAck !== !own_fetch) begin n_fail++; $display("FAIL rnd_ack it=%0d got=%b%b exp=%b%b", it, fetchAck, dataAck, own_fetch, !own_fetch); end
                n_checks++; if (timeoutErr !== to) begin n_fail++; $display("FAIL rnd_terr it=%0d got=%b exp=%b", it, timeoutErr, to); end
                n_checks++; if (fetchRdata !== exp_frd || dataRdata !== exp_drd) begin n_fail++; $display("FAIL rnd_rdata it=%0d got=%h/%h exp=%h/%h", it, fetchRdata, dataRdata, exp_frd, exp_drd); end
                $display("txn rnd %0d.%0d: %s addr=%h we=%b waits=%0d timeout=%b", it, k, own_fetch ? "F" : "D", a, we, waits, to);
                if (own_fetch) fetchReq = 1'b0; else dataReq = 1'b0;
            end
            @(negedge clk);
            n_checks++; if (arbState !== 2'd0 || fetchAck !== 1'b0 || dataAck !== 1'b0 || timeoutErr !== 1'b0) begin n_fail++; $display("FAIL rnd_quiet it=%0d state=%0d acks=%b%b terr=%b", it, arbState, fetchAck, dataAck, timeoutErr); end
        end
    endtask

    initial begin
        reset = 1'b1; fetchReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0;
        fetchAddr = '0; dataAddr = '0; dataWdata = '0; memRdata = '0; memReady = 1'b0;
        exp_frd = '0; exp_drd = '0; last_fetch = 1'b0;
        test_reset();
        test_single_fetch();
        test_store();
        test_timeout();
        test_idle_ready();
        test_ack_mask();
        test_contention();
        test_mid_reset();
        test_random(30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
